// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
//
// Purpose: common definitions used by instr_fetch_unit and fetch_fifo.
//   fetch_entry_t : one prefetched instruction together with its byte PC
//   INSTR_W/PC_W  : instruction and address widths
//   PC_INC        : sequential PC step (one 32-bit word)
//   DEFAULT_RESET_PC : PC loaded on reset unless overridden
// Ports: none (package).

package fetch_pkg;

   localparam int          INSTR_W          = 32;
   localparam int          PC_W             = 32;
   localparam logic [31:0] PC_INC           = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   // Word-align a byte address by clearing the two low bits.
   function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
      return {addr[PC_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO with flush and push-while-full-and-popping
//
// Purpose: synchronous FIFO of fetch_entry_t. Head is read directly from the
//   storage flops so downstream sees registered values only.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   flush           : empty the FIFO (pointers to zero); overrides push/pop
//   push, push_data : write request and entry
//   pop             : advance head (ignored when empty)
//   full, empty     : occupancy flags
//   head            : entry at the read pointer (stale but stable when empty)

module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   output logic         full,
   output logic         empty,
   output fetch_entry_t head
);

   localparam int AW = $clog2(DEPTH);

   // Pointers carry an extra wrap bit to distinguish full from empty.
   logic [AW:0]  wptr_q, wptr_d;
   logic [AW:0]  rptr_q, rptr_d;
   fetch_entry_t mem_q [DEPTH];
   fetch_entry_t mem_d [DEPTH];
   logic         do_push, do_pop;

   assign empty   = (wptr_q == rptr_q);
   assign full    = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
   assign do_pop  = pop && !empty;
   // When full, a same-cycle pop frees the slot being written; the head is
   // read from the old contents before the edge, so no hazard.
   assign do_push = push && (!full || do_pop);
   assign head    = mem_q[rptr_q[AW-1:0]];

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      mem_d  = mem_q;
      if (flush) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (do_push) begin
            mem_d[wptr_q[AW-1:0]] = push_data;
            wptr_d = wptr_q + 1'b1;
         end
         if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         mem_q  <= mem_d;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - program counter, ROM fetch and prefetch queue to decode
//
// Purpose: holds the PC, drives it as the ROM address, pushes {pc, rom_data}
//   into fetch_fifo, and presents the FIFO head to decode. A redirect flushes
//   all prefetched entries and reloads the PC with the word-aligned target.
// Optional feature: FETCH_MISALIGN_TRAP_EN -- a misaligned redirect target
//   sets sticky misalign_err and halts fetching until an aligned redirect.
//   Without it the low target bits are dropped and misalign_err is 0.
// Ports:
//   clk, reset                : clock, asynchronous active-high reset
//   rom_addr / rom_data       : ROM byte address (= pc_q) / combinational word
//   redirect_valid/redirect_pc: taken branch or jump and its target
//   out_valid/out_ready       : decode handshake
//   out_instr/out_pc          : head instruction and its PC
//   misalign_err              : sticky misaligned-target flag

module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] rom_addr,
   input  logic [31:0] rom_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic        misalign_err
);

   logic [31:0]  pc_q, pc_d;
   logic         fifo_full, fifo_empty;
   logic         fifo_push, fifo_pop;
   logic         fetch_en;
   fetch_entry_t head, push_entry;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic halt_q, halt_d;
   logic misalign_err_q, misalign_err_d;

   always_comb begin
      halt_d         = halt_q;
      misalign_err_d = misalign_err_q;
      if (redirect_valid) begin
         if (redirect_pc[1:0] != 2'b00) begin
            halt_d         = 1'b1;
            misalign_err_d = 1'b1;
         end else begin
            halt_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         halt_q         <= 1'b0;
         misalign_err_q <= 1'b0;
      end else begin
         halt_q         <= halt_d;
         misalign_err_q <= misalign_err_d;
      end
   end

   assign fetch_en     = !halt_q;
   assign misalign_err = misalign_err_q;
`else
   assign fetch_en     = 1'b1;
   assign misalign_err = 1'b0;
`endif

   assign out_valid = !fifo_empty;
   // A pop coinciding with a redirect is still taken by decode; the flush
   // then discards whatever remains.
   assign fifo_pop  = out_valid && out_ready;

   always_comb begin
      pc_d      = pc_q;
      fifo_push = 1'b0;
      if (redirect_valid) begin
         pc_d = align_pc(redirect_pc);
      end else if (fetch_en && (!fifo_full || fifo_pop)) begin
         fifo_push = 1'b1;
         pc_d      = pc_q + PC_INC;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign push_entry.pc    = pc_q;
   assign push_entry.instr = rom_data;

   fetch_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (reset),
      .flush     (redirect_valid),
      .push      (fifo_push),
      .push_data (push_entry),
      .pop       (fifo_pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (head)
   );

   assign rom_addr  = pc_q;
   assign out_instr = head.instr;
   assign out_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit

module tb_instr_fetch_unit;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [31:0] rom [0:63];

   logic [31:0] rom_addr, rom_data, redirect_pc, out_instr, out_pc;
   logic        redirect_valid, out_valid, out_ready, misalign_err;

   logic [31:0] rom_addr2, rom_data2, out_instr2, out_pc2;
   logic        out_valid2, misalign_err2;

   int errors = 0;
   int checks = 0;

   assign rom_data  = rom[rom_addr[7:2]];
   assign rom_data2 = rom[rom_addr2[7:2]];

   instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_pc(out_pc), .misalign_err(misalign_err)
   );

   instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut2 (
      .clk(clk), .reset(reset), .rom_addr(rom_addr2), .rom_data(rom_data2),
      .redirect_valid(1'b0), .redirect_pc(32'h0),
      .out_valid(out_valid2), .out_ready(1'b1), .out_instr(out_instr2),
      .out_pc(out_pc2), .misalign_err(misalign_err2)
   );

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      out_ready = 1'b0;
      repeat (6) @(negedge clk);
      redirect_valid = 1'b1; redirect_pc = 32'h40;
      #2 reset = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", out_pc); end
      checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=0", out_instr); end
      checks++; if (rom_addr !== 32'h0) begin errors++; $display("FAIL reset_rom_addr got=%h exp=0", rom_addr); end
      checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign got=%b exp=0", misalign_err); end
      checks++; if (rom_addr2 !== 32'hFFFF_FFF8) begin errors++; $display("FAIL reset_rom_addr2 got=%h exp=fffffff8", rom_addr2); end
      @(negedge clk);
      redirect_valid = 1'b0;
      checks++; if (out_valid !== 1'b0 || rom_addr !== 32'h0) begin errors++; $display("FAIL reset_hold got=%b/%h exp=0/0", out_valid, rom_addr); end
      reset = 1'b0;
   endtask

   task automatic test_stream();
      do_reset();
      out_ready = 1'b1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_first_valid got=%b exp=0", out_valid); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, out_valid); end
         checks++; if (out_pc !== 32'(i * 4)) begin errors++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, out_pc, 32'(i * 4)); end
         checks++; if (out_instr !== rom[i]) begin errors++; $display("FAIL stream_instr[%0d] got=%h exp=%h", i, out_instr, rom[i]); end
      end
   endtask

   task automatic test_stall();
      do_reset();
      out_ready = 1'b0;
      repeat (10) @(negedge clk);
      checks++; if (rom_addr !== 32'h10) begin errors++; $display("FAIL stall_rom_addr got=%h exp=10", rom_addr); end
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin errors++; $display("FAIL stall_head got=%b/%h exp=1/0", out_valid, out_pc); end
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++; if (out_valid !== 1'b1 || out_pc !== 32'(i * 4)) begin errors++; $display("FAIL stall_drain[%0d] got=%b/%h exp=1/%h", i, out_valid, out_pc, 32'(i * 4)); end
         @(negedge clk);
      end
   endtask

   task automatic test_redirect();
      do_reset();
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (rom_addr !== 32'hC || out_valid !== 1'b1) begin errors++; $display("FAIL redir_pre got=%h/%b exp=c/1", rom_addr, out_valid); end
      redirect_valid = 1'b1; redirect_pc = 32'h40;
      @(negedge clk);
      redirect_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_gap got=%b exp=0", out_valid); end
      checks++; if (rom_addr !== 32'h40) begin errors++; $display("FAIL redir_rom_addr got=%h exp=40", rom_addr); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h40) begin errors++; $display("FAIL redir_target got=%b/%h exp=1/40", out_valid, out_pc); end
      checks++; if (out_instr !== rom[16]) begin errors++; $display("FAIL redir_instr got=%h exp=%h", out_instr, rom[16]); end
   endtask

   task automatic test_redirect_pop_full();
      do_reset();
      out_ready = 1'b0;
      repeat (5) @(negedge clk);
      checks++; if (rom_addr !== 32'h10) begin errors++; $display("FAIL rpf_full got=%h exp=10", rom_addr); end
      out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
      @(negedge clk);
      redirect_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rpf_gap got=%b exp=0", out_valid); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h80) begin errors++; $display("FAIL rpf_target got=%b/%h exp=1/80", out_valid, out_pc); end
      checks++; if (out_instr !== rom[32]) begin errors++; $display("FAIL rpf_instr got=%h exp=%h", out_instr, rom[32]); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h84) begin errors++; $display("FAIL rpf_next got=%b/%h exp=1/84", out_valid, out_pc); end
   endtask

   task automatic test_pc_wrap();
      logic [31:0] exp_pc [3];
      exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0;
      do_reset();
      checks++; if (out_valid2 !== 1'b0 || rom_addr2 !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_start got=%b/%h exp=0/fffffff8", out_valid2, rom_addr2); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (out_valid2 !== 1'b1 || out_pc2 !== exp_pc[i]) begin errors++; $display("FAIL wrap_pc[%0d] got=%b/%h exp=1/%h", i, out_valid2, out_pc2, exp_pc[i]); end
      end
   endtask

   task automatic test_misalign();
      do_reset();
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      redirect_valid = 1'b1; redirect_pc = 32'h22;
      @(negedge clk);
      redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      for (int i = 0; i < 4; i++) begin
         checks++; if (misalign_err !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL mis_halt[%0d] got=%b/%b exp=1/0", i, misalign_err, out_valid); end
         @(negedge clk);
      end
      checks++; if (rom_addr !== 32'h20) begin errors++; $display("FAIL mis_rom_addr got=%h exp=20", rom_addr); end
      redirect_valid = 1'b1; redirect_pc = 32'h24;
      @(negedge clk);
      redirect_valid = 1'b0;
      checks++; if (out_valid !== 1'b0 || misalign_err !== 1'b1) begin errors++; $display("FAIL mis_resume_gap got=%b/%b exp=0/1", out_valid, misalign_err); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h24 || misalign_err !== 1'b1) begin errors++; $display("FAIL mis_resume got=%b/%h/%b exp=1/24/1", out_valid, out_pc, misalign_err); end
      @(negedge clk);
      checks++; if (out_pc !== 32'h28 || misalign_err !== 1'b1) begin errors++; $display("FAIL mis_next got=%h/%b exp=28/1", out_pc, misalign_err); end
      do_reset();
      checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL mis_cleared got=%b exp=0", misalign_err); end
`else
      checks++; if (out_valid !== 1'b0 || misalign_err !== 1'b0) begin errors++; $display("FAIL mis_gap got=%b/%b exp=0/0", out_valid, misalign_err); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h20 || misalign_err !== 1'b0) begin errors++; $display("FAIL mis_aligned got=%b/%h/%b exp=1/20/0", out_valid, out_pc, misalign_err); end
`endif
   endtask

   // Reference: a queue of pending PCs plus the next PC to fetch, updated by
   // the fetch rules once per clock.
   task automatic test_random();
      logic [31:0] q [$];
      logic [31:0] mpc, head, rpc;
      bit          mhalt, merr, rdy, rv, pop, room;
      mpc = 32'h0; mhalt = 1'b0; merr = 1'b0;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         rdy = ($urandom_range(0, 9) < 7);
         rv  = ($urandom_range(0, 19) == 0);
         rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1F)) : ($urandom & 32'h0000_00FC);
         if ($urandom_range(0, 3) == 0) rpc[1:0] = 2'($urandom);
         out_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
         #1;
         checks++; if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", c, out_valid, q.size() != 0); end
         if (q.size() != 0) begin
            head = q[0];
            checks++; if (out_pc !== head || out_instr !== rom[head[7:2]]) begin errors++; $display("FAIL rnd_head[%0d] got=%h/%h exp=%h/%h", c, out_pc, out_instr, head, rom[head[7:2]]); end
         end
         checks++; if (rom_addr !== mpc) begin errors++; $display("FAIL rnd_rom_addr[%0d] got=%h exp=%h", c, rom_addr, mpc); end
         checks++; if (misalign_err !== merr) begin errors++; $display("FAIL rnd_misalign[%0d] got=%b exp=%b", c, misalign_err, merr); end
         @(posedge clk);
         pop  = (q.size() != 0) && rdy;
         room = (q.size() < DEPTH) || pop;
         if (pop) void'(q.pop_front());
         if (rv) begin
            q.delete();
            mpc = {rpc[31:2], 2'b00};
`ifdef FETCH_MISALIGN_TRAP_EN
            if (rpc[1:0] != 2'b00) begin mhalt = 1'b1; merr = 1'b1; end
            else mhalt = 1'b0;
`endif
         end else if (room && !mhalt) begin
            q.push_back(mpc);
            mpc = mpc + 32'd4;
         end
         @(negedge clk);
      end
      redirect_valid = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         if (i % 2 == 0) rom[i] = {12'(i), 5'd1, 3'b000, 5'd1, 7'h13};
         else            rom[i] = {7'd0, 5'(i >> 1), 5'd1, 3'b000, 5'd2, 7'h33};
      end
      redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_redirect_pop_full();
      test_pc_wrap();
      test_misalign();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
